// File: rtl/seq_det_param_pkg.sv
// Shared types and helpers for the programmable sequence detector.
package seq_det_param_pkg;

    // Detector progress: no bits held, partially filled, full pattern window held
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        ARMED   = 2'd2
    } state_t;

    // Width needed to hold a length in 0..max_w
    function automatic int len_w(input int max_w);
        return $clog2(max_w + 1);
    endfunction

    // Length-mask bit: history bit idx takes part in the compare when idx < len
    function automatic logic in_len(input int idx, input int len);
        return idx < len;
    endfunction

endpackage

// File: rtl/seq_det_param_hist_shift.sv
// Serial history shift register plus fill counter clamped to the active length.
// Presents the post-consume history/fill so the top can detect a match on the
// same edge that shifts the completing bit in.
module seq_det_param_hist_shift #(
    parameter int MAX_W = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             consume,
    input  logic             clear,
    input  logic             in,
    input  logic [LEN_W-1:0] len,
    output logic [MAX_W-1:0] nxt_hist,
    output logic [LEN_W-1:0] nxt_fill
);

    // Only MAX_W-1 bits are stored: the oldest bit of the window is needed for
    // the compare on the consume edge but never again after that.
    logic [MAX_W-2:0] hist;
    logic [LEN_W-1:0] fill;

    // Post-consume view; fill only counts up while below len so it never overflows
    always_comb begin
        nxt_hist = {hist, in};
        nxt_fill = (fill < len) ? fill + LEN_W'(1) : len;
    end

    // Clear (config load / non-overlap match) beats consume
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
            fill <= '0;
        end else if (clear) begin
            hist <= '0;
            fill <= '0;
        end else if (consume) begin
            hist <= nxt_hist[MAX_W-2:0];
            fill <= nxt_fill;
        end
    end

endmodule

// File: rtl/seq_det_param.sv
// Runtime-programmable serial bit-sequence detector.
// Pattern up to MAX_W bits (first received bit = pattern[len-1]), overlapping or
// restart-after-match modes, registered one-cycle y pulse, saturating match count.
// Optional build macro SEQ_MASK_EN adds a cfg_mask port of don't-care bits.
module seq_det_param
    import seq_det_param_pkg::*;
#(
    parameter int               MAX_W       = 8,
    parameter int               CNT_W       = 8,
    parameter logic [MAX_W-1:0] RST_PATTERN = 'h0C,
    parameter int               RST_LEN     = 4,
    parameter bit               RST_OVERLAP = 1'b1,
    localparam int              LEN_W       = len_w(MAX_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in,
    input  logic             cfg_load,
    input  logic [MAX_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
`ifdef SEQ_MASK_EN
    input  logic [MAX_W-1:0] cfg_mask,
`endif
    input  logic             cnt_clr,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);

    logic [MAX_W-1:0] pat;
    logic [LEN_W-1:0] len;
    logic             ovl;
    logic [LEN_W-1:0] cfg_len_c;
    logic [MAX_W-1:0] lmask;
    logic [MAX_W-1:0] care;
    logic [MAX_W-1:0] nxt_hist;
    logic [LEN_W-1:0] nxt_fill;
    logic             consume;
    logic             match;
    logic             clear;
    state_t           state, state_nxt;

    // A config load owns the cycle: the bit presented with it is dropped
    assign consume   = in_valid & ~cfg_load;
    assign cfg_len_c = (cfg_len > LEN_W'(MAX_W)) ? LEN_W'(MAX_W) : cfg_len;

`ifdef SEQ_MASK_EN
    logic [MAX_W-1:0] mask;

    // Don't-care mask travels with the rest of the config
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          mask <= '0;
        else if (cfg_load) mask <= cfg_mask;
    end

    assign care = lmask & ~mask;
`else
    assign care = lmask;
`endif

    // Active configuration registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat <= RST_PATTERN;
            len <= LEN_W'(RST_LEN);
            ovl <= RST_OVERLAP;
        end else if (cfg_load) begin
            pat <= cfg_pattern;
            len <= cfg_len_c;
            ovl <= cfg_overlap;
        end
    end

    for (genvar i = 0; i < MAX_W; i++) begin : g_lmask
        assign lmask[i] = in_len(i, int'(len));
    end

    seq_det_param_hist_shift #(
        .MAX_W (MAX_W),
        .LEN_W (LEN_W)
    ) u_hist (
        .clk      (clk),
        .rst      (rst),
        .consume  (consume),
        .clear    (clear),
        .in       (in),
        .len      (len),
        .nxt_hist (nxt_hist),
        .nxt_fill (nxt_fill)
    );

    // len==0 disables matching even though nxt_fill==len trivially holds
    assign match = consume && (len != '0) && (nxt_fill == len) &&
                   (((nxt_hist ^ pat) & care) == '0);
    assign clear = cfg_load | (match & ~ovl);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= EMPTY;
        else      state <= state_nxt;
    end

    // Next state follows the post-consume fill level
    always_comb begin
        state_nxt = state;
        if (cfg_load) begin
            state_nxt = EMPTY;
        end else if (consume) begin
            if (match && !ovl)         state_nxt = EMPTY;
            else if (nxt_fill == '0)   state_nxt = EMPTY;
            else if (nxt_fill == len)  state_nxt = ARMED;
            else                       state_nxt = FILLING;
        end
    end

    // State-decoded output
    always_comb begin
        armed = (state == ARMED);
    end

    // Registered match pulse, one cycle after the completing bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) y <= 1'b0;
        else      y <= match;
    end

    // Saturating match counter; clear wins over a coincident match
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                             match_cnt <= '0;
        else if (cnt_clr)                     match_cnt <= '0;
        else if (match && (match_cnt != '1))  match_cnt <= match_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_seq_det_param.sv
// Scoreboard bench for seq_det_param: stimulus pushes expected pulse cycle and
// count, a negedge monitor pops and compares whenever y is (or should be) high.
module tb_seq_det_param;

    localparam int MAX_W = 8;
    localparam int LEN_W = $clog2(MAX_W + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             din = 1'b0;
    logic             cfg_load = 1'b0;
    logic [MAX_W-1:0] cfg_pattern = 8'h0C;
    logic [LEN_W-1:0] cfg_len = 4'd4;
    logic             cfg_overlap = 1'b1;
    logic             cnt_clr = 1'b0;
    logic             y, armed, y_sat, armed_sat;
    logic [7:0]       match_cnt;
    logic [1:0]       cnt_sat;
`ifdef SEQ_MASK_EN
    logic [MAX_W-1:0] cfg_mask = '0;
`endif

    typedef struct { int cyc; int cnt; } exp_t;
    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   exp_cnt = 0;

    seq_det_param #(.MAX_W(MAX_W), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
`ifdef SEQ_MASK_EN
        .cfg_mask(cfg_mask),
`endif
        .cnt_clr(cnt_clr), .y(y), .match_cnt(match_cnt), .armed(armed)
    );

    seq_det_param #(.MAX_W(MAX_W), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
`ifdef SEQ_MASK_EN
        .cfg_mask(cfg_mask),
`endif
        .cnt_clr(cnt_clr), .y(y_sat), .match_cnt(cnt_sat), .armed(armed_sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares whenever a pulse is seen or expected on this cycle
    always @(negedge clk) begin
        bit exp_y;
        exp_y = (q.size() > 0) && (q[0].cyc == cyc);
        if (exp_y || y) begin
            check("y_pulse", int'(y), int'(exp_y));
            if (exp_y) begin
                check("cnt_at_pulse", int'(match_cnt), q[0].cnt);
                void'(q.pop_front());
            end
        end
    end

    // One cycle of stimulus; the bit is consumed on the following posedge
    task automatic drive(input bit v, input bit b, input bit ld, input bit clr, input bit pulse);
        @(negedge clk);
        #1;
        in_valid = v;
        din      = b;
        cfg_load = ld;
        cnt_clr  = clr;
        if (pulse) begin
            exp_cnt = clr ? 0 : ((exp_cnt == 255) ? 255 : exp_cnt + 1);
            q.push_back('{cyc: cyc + 1, cnt: exp_cnt});
        end else if (clr) begin
            exp_cnt = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // s: bits in arrival order; p: '1' where that bit completes a match
    task automatic run(input string s, input string p);
        for (int i = 0; i < s.len(); i++)
            drive(1'b1, s[i] == "1", 1'b0, 1'b0, p[i] == "1");
    endtask

    task automatic load(input logic [MAX_W-1:0] pt, input logic [LEN_W-1:0] ln, input bit ov);
        cfg_pattern = pt;
        cfg_len     = ln;
        cfg_overlap = ov;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_y", int'(y), 0);
        check("rst_cnt", int'(match_cnt), 0);
        check("rst_armed", int'(armed), 0);
        @(negedge clk);
        rst = 1'b1;

        // Default 1100 overlap: completes at consumed bits 6, 13 and 20
        run("0011000111100110110000", "0000010000001000000100");
        idle(1);
        check("default_cnt", int'(match_cnt), 3);

        // 1010 overlapping -> two matches; non-overlapping -> one
        load(8'h0A, 4'd4, 1'b1);
        run("101010", "000101");
        load(8'h0A, 4'd4, 1'b0);
        run("101010", "000100");
        idle(1);
        check("novl_armed_after", int'(armed), 0);

        // 1100 with in_valid gaps: 1,gap,1,gap,gap,0,0
        load(8'h0C, 4'd4, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // cfg_load on the completing bit's edge discards the bit
        run("0110", "0000");
        idle(1);
        check("armed_before_load", int'(armed), 1);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        check("armed_after_load", int'(armed), 0);
        run("1100", "0001");

        // cnt_clr coincident with a match
        run("110", "000");
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1);
        check("clr_wins_cnt", int'(match_cnt), 0);

        // 2-bit counter saturation over five matches
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            run("1100", "0001");
            @(posedge clk);
            #1;
            check("sat_cnt", int'(cnt_sat), (k < 3) ? k + 1 : 3);
        end

        // len 0 never matches and stays EMPTY
        load(8'h0C, 4'd0, 1'b1);
        run("11001100", "00000000");
        idle(1);
        check("len0_armed", int'(armed), 0);

        // len above MAX_W clamps to 8
        load(8'hA5, 4'd15, 1'b1);
        run("10100101", "00000001");
        idle(1);
        check("clamp_armed", int'(armed), 1);

        // Async reset mid-pattern
        load(8'h0C, 4'd4, 1'b1);
        run("11", "00");
        idle(1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_y", int'(y), 0);
        check("midrst_cnt", int'(match_cnt), 0);
        check("midrst_armed", int'(armed), 0);
        #2 rst = 1'b1;
        exp_cnt = 0;
        run("00", "00");
        idle(1);
        check("post_rst_cnt", int'(match_cnt), 0);

`ifdef SEQ_MASK_EN
        // Mask bit 1 makes the third pattern bit don't-care
        cfg_mask = 8'h02;
        load(8'h0C, 4'd4, 1'b1);
        run("11001110", "00010001");
        cfg_mask = '0;
`endif

        idle(3);
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
